// File: rtl/cal_pkg.sv
// rtl/cal_pkg.sv - shared calendar constants, BCD digit type and leap/BCD helpers
package cal_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [7:0] MON_FEB = 8'h02;
  localparam logic [7:0] MON_DEC = 8'h12;

  // Index 1 = January; entries are BCD last days of a non-leap year.
  localparam logic [12:1][7:0] MONTH_LEN = {8'h31, 8'h30, 8'h31, 8'h30, 8'h31, 8'h31,
                                            8'h30, 8'h31, 8'h30, 8'h31, 8'h28, 8'h31};

  // A two-digit BCD value is divisible by 4 iff (2*tens + units) is.
  function automatic logic bcd_div4(input bcd_digit_t tens, input bcd_digit_t units);
    return tens[0] ? (units == 4'd2 || units == 4'd6)
                   : (units == 4'd0 || units == 4'd4 || units == 4'd8);
  endfunction

  function automatic logic bcd_is_leap(input logic [15:0] year, input int digits,
                                       input logic y00_leap);
    logic lo_zero;
    lo_zero = (year[7:0] == 8'h00);
    if (digits == 2) return lo_zero ? y00_leap : bcd_div4(year[7:4], year[3:0]);
    return lo_zero ? bcd_div4(year[15:12], year[11:8]) : bcd_div4(year[7:4], year[3:0]);
  endfunction

  function automatic logic [15:0] bin_to_bcd16(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic rst_date_ok(input int d, input int m, input int y,
                                       input int digits, input logic y00_leap);
    logic [7:0] lim;
    if (m < 1 || m > 12 || d < 1 || y < 0) return 1'b0;
    if (y >= ((digits == 4) ? 10000 : 100)) return 1'b0;
    lim = MONTH_LEN[m[3:0]];
    if (m == 2 && bcd_is_leap(bin_to_bcd16(y), digits, y00_leap)) lim = 8'h29;
    return d <= (10 * int'(lim[7:4]) + int'(lim[3:0]));
  endfunction

endpackage

// File: rtl/cal_month_len.sv
// rtl/cal_month_len.sv - BCD last day of a BCD month; returns 00 for an illegal month
module cal_month_len
  import cal_pkg::*;
(
  input  logic [7:0] mon_i,
  input  logic       is_leap_i,
  output logic [7:0] last_day_o
);

  logic       mon_ok;
  logic [3:0] idx;

  always_comb begin
    mon_ok     = (mon_i[7:4] == 4'd0 && mon_i[3:0] >= 4'd1 && mon_i[3:0] <= 4'd9) ||
                 (mon_i[7:4] == 4'd1 && mon_i[3:0] <= 4'd2);
    idx        = mon_i[4] ? (mon_i[3:0] + 4'd10) : mon_i[3:0];
    last_day_o = 8'h00;
    if (mon_ok) begin
      last_day_o = MONTH_LEN[idx];
      if (mon_i == MON_FEB && is_leap_i) last_day_o = 8'h29;
    end
  end

endmodule

// File: rtl/calendar_date_ctr.sv
// rtl/calendar_date_ctr.sv - BCD day/month/year calendar counter with validated load
module calendar_date_ctr
  import cal_pkg::*;
#(
  parameter int YEAR_DIGITS = 2,
  parameter bit Y00_LEAP    = 1'b1,
  parameter int RST_DAY     = 1,
  parameter int RST_MON     = 3,
  parameter int RST_YEAR    = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     day_tick,
  input  logic                     load_en,
  input  logic [7:0]               load_day,
  input  logic [7:0]               load_mon,
  input  logic [4*YEAR_DIGITS-1:0] load_year,
  output logic [1:0]               day_10,
  output logic [3:0]               day_1,
  output logic                     mon_10,
  output logic [3:0]               mon_1,
  output logic [4*YEAR_DIGITS-1:0] year_bcd,
  output logic                     wrap_tick,
  output logic                     load_err
);

  localparam int          YW      = 4 * YEAR_DIGITS;
  localparam logic [15:0] RST_D16 = bin_to_bcd16(RST_DAY);
  localparam logic [15:0] RST_M16 = bin_to_bcd16(RST_MON);
  localparam logic [15:0] RST_Y16 = bin_to_bcd16(RST_YEAR);

  if (!(YEAR_DIGITS == 2 || YEAR_DIGITS == 4) ||
      !rst_date_ok(RST_DAY, RST_MON, RST_YEAR, YEAR_DIGITS, Y00_LEAP)) begin : g_bad_cfg
    $error("calendar_date_ctr: illegal YEAR_DIGITS or reset date");
  end

  logic [5:0]    day_q, day_d;
  logic [4:0]    mon_q, mon_d;
  logic [YW-1:0] year_q, year_d, year_inc;
  logic          wrap_q, wrap_d, err_q, err_d;
  logic          year_carry, ld_nib_ok, ld_ok, cur_leap, ld_leap;
  logic [7:0]    cur_last, ld_last;

  assign cur_leap = bcd_is_leap(16'(year_q), YEAR_DIGITS, Y00_LEAP);
  assign ld_leap  = bcd_is_leap(16'(load_year), YEAR_DIGITS, Y00_LEAP);

  cal_month_len u_len_cur (.mon_i({3'b000, mon_q}), .is_leap_i(cur_leap), .last_day_o(cur_last));
  cal_month_len u_len_ld  (.mon_i(load_mon),        .is_leap_i(ld_leap),  .last_day_o(ld_last));

  always_comb begin
    year_inc   = year_q;
    year_carry = 1'b1;
    ld_nib_ok  = (load_day[7:4] <= 4'd9) && (load_day[3:0] <= 4'd9) &&
                 (load_mon[7:4] <= 4'd9) && (load_mon[3:0] <= 4'd9);
    for (int i = 0; i < YEAR_DIGITS; i++) begin
      if (load_year[4*i +: 4] > 4'd9) ld_nib_ok = 1'b0;
      if (year_carry) begin
        if (year_q[4*i +: 4] == 4'd9) begin
          year_inc[4*i +: 4] = 4'd0;
        end else begin
          year_inc[4*i +: 4] = year_q[4*i +: 4] + 4'd1;
          year_carry         = 1'b0;
        end
      end
    end
    // ld_last is 00 for an illegal month, so the day compare rejects it too.
    ld_ok = ld_nib_ok && (ld_last != 8'h00) && (load_day != 8'h00) && (load_day <= ld_last);
  end

  always_comb begin
    day_d  = day_q;
    mon_d  = mon_q;
    year_d = year_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (load_en) begin
      if (ld_ok) begin
        day_d  = load_day[5:0];
        mon_d  = load_mon[4:0];
        year_d = load_year;
      end else begin
        err_d = 1'b1;
      end
    end else if (day_tick) begin
      if ({2'b00, day_q} == cur_last) begin
        day_d = 6'h01;
        if ({3'b000, mon_q} == MON_DEC) begin
          mon_d  = 5'h01;
          year_d = year_inc;
          wrap_d = year_carry;
        end else if (mon_q[3:0] == 4'd9) begin
          mon_d = 5'h10;
        end else begin
          mon_d = mon_q + 5'd1;
        end
      end else if (day_q[3:0] == 4'd9) begin
        day_d = {day_q[5:4] + 2'd1, 4'd0};
      end else begin
        day_d = day_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      day_q  <= RST_D16[5:0];
      mon_q  <= RST_M16[4:0];
      year_q <= RST_Y16[YW-1:0];
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      day_q  <= day_d;
      mon_q  <= mon_d;
      year_q <= year_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign day_10    = day_q[5:4];
  assign day_1     = day_q[3:0];
  assign mon_10    = mon_q[4];
  assign mon_1     = mon_q[3:0];
  assign year_bcd  = year_q;
  assign wrap_tick = wrap_q;
  assign load_err  = err_q;

endmodule

// File: doc/calendar_date_ctr.md
CALENDAR_DATE_CTR -- requirements
Module: calendar_date_ctr

Interface
REQ-001 SHALL have parameter YEAR_DIGITS, default 2: number of BCD year digits; legal values 2 or 4.
REQ-002 SHALL have parameter Y00_LEAP, default 1: when YEAR_DIGITS=2, year 00 is treated as a leap year if 1.
REQ-003 SHALL have parameters RST_DAY / RST_MON / RST_YEAR, defaults 1 / 3 / 24 (binary values): the date loaded on reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port day_tick, input, 1 bit: one-cycle pulse at the 23:59:59 rollover; each high cycle advances the date by one day.
REQ-007 SHALL have port load_en, input, 1 bit: one-cycle request to set the date from the load_* ports.
REQ-008 SHALL have port load_day, input, 8 bits: BCD day; tens digit in [7:4], units in [3:0].
REQ-009 SHALL have port load_mon, input, 8 bits: BCD month; same packing as load_day.
REQ-010 SHALL have port load_year, input, 4*YEAR_DIGITS bits: BCD year; least-significant digit in [3:0].
REQ-011 SHALL have outputs day_10 (2 bits), day_1 (4 bits), mon_10 (1 bit), mon_1 (4 bits): registered BCD day and month.
REQ-012 SHALL have output year_bcd, 4*YEAR_DIGITS bits: registered BCD year, same packing as load_year.
REQ-013 SHALL have output wrap_tick, 1 bit: one-cycle pulse when the year wraps from all-9s to all-0s.
REQ-014 SHALL have output load_err, 1 bit: one-cycle pulse when a load request is rejected.

Function
REQ-015 SHALL count directly in BCD; no binary-to-BCD conversion.
REQ-016 SHALL update outputs on the clock edge at which day_tick is sampled high; latency is 1 cycle.
REQ-017 SHALL use month lengths 31/28/31/30/31/30/31/31/30/31/30/31, with February = 29 in a leap year.
REQ-018 SHALL apply the leap rule for YEAR_DIGITS=4 as: divisible by 4, and not divisible by 100 unless divisible by 400.
REQ-019 SHALL apply the leap rule for YEAR_DIGITS=2 as: divisible by 4; year 00 is leap if and only if Y00_LEAP=1.
REQ-020 SHALL, on a tick at the last day of the month, set day to 01 and increment the month.
REQ-021 SHALL, on a tick at the last day of month 12, set the date to 01-01 and increment the year.
REQ-022 SHALL, on a year increment from all-9s, wrap the year to all-0s and assert wrap_tick in that same update cycle.
REQ-023 SHALL validate every load request and reject it if any of the following holds: any nibble > 9; month 0 or > 12; day 0; day > length of the loaded month in the loaded year.
REQ-024 SHALL, on a valid load, take the new date at the next edge, with no wrap_tick.
REQ-025 SHALL, on a rejected load, leave the date unchanged and pulse load_err for 1 cycle.
REQ-026 SHALL give load_en priority when load_en and day_tick are high together: the tick is discarded, including when the load is rejected.
REQ-027 SHALL treat back-to-back day_tick cycles as one increment each.
REQ-028 SHALL keep wrap_tick and load_err low in all other cycles.

Reset
REQ-029 SHALL, while rst_n is low, immediately force the date to RST_DAY/RST_MON/RST_YEAR in BCD and drive wrap_tick=0, load_err=0.
REQ-030 SHALL let a reset that occurs during a load or a tick override it completely; no partial update survives.
REQ-031 SHALL reject an illegal reset date at elaboration.

Structure
REQ-032 SHALL place the following in shared package cal_pkg: the month-length constant table, the BCD digit type, and the month numbers for February and December.
REQ-033 SHALL implement month length in one combinational sub-module, cal_month_len, with inputs month BCD and is_leap and output the last day in BCD.
REQ-034 SHALL instantiate cal_month_len twice: once for the current date and once for load validation.

Verification
REQ-035 SHALL test: date 28-02-24, one tick -> 29-02-24; second tick -> 01-03-24.
REQ-036 SHALL test: date 28-02-23, one tick -> 01-03-23; wrap_tick stays 0.
REQ-037 SHALL test: date 31-12-99 (YEAR_DIGITS=2), one tick -> 01-01-00 with a 1-cycle wrap_tick; with Y00_LEAP=0, 28-02-00 plus one tick -> 01-03-00.
REQ-038 SHALL test: load 31-04-25 -> date unchanged and 1-cycle load_err; load 1A-05-25 -> rejected.
REQ-039 SHALL test: load_en and day_tick high together with load 15-06-30 -> date 15-06-30 (not 16-06-30).
REQ-040 SHALL test: YEAR_DIGITS=4, date 28-02-2100, tick -> 01-03-2100; date 28-02-2000, tick -> 29-02-2000; rst_n pulsed low mid-run -> 01-03-24 immediately.
